// File: rtl/core_seq.sv
// Multi-cycle fetch/execute/writeback sequencer owning the PC and the imem fetch handshake.
// Optional performance counters are enabled by defining CORE_SEQ_PERF_EN.
module core_seq #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            exu_wen,
  input  logic [4:0]      rd,
  input  logic            npc_sel,
  input  logic [XLEN-1:0] npc_target,
  output logic            gpr_wen,
  output logic [XLEN-1:0] pc_val,
  output logic            halt,
  output logic            halt_err,
  output logic [XLEN-1:0] perf_cycles,
  output logic [XLEN-1:0] perf_retired
);

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [2:0] {StFetch, StWait, StExec, StWb, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            req_q, req_d;
  logic            halt_q, halt_d;
  logic            halt_err_q, halt_err_d;
  logic            wen_q, wen_d;
  logic [4:0]      rd_q, rd_d;
  logic            sel_q, sel_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            retire;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halt_d       = halt_q;
    halt_err_d   = halt_err_q;
    wen_d        = wen_q;
    rd_d         = rd_q;
    sel_d        = sel_q;
    target_d     = target_q;
    gpr_wen      = 1'b0;
    retire       = 1'b0;
    case (state_q)
      // req_q is low for the first cycle after reset, so no handshake can complete then.
      StFetch: if (req_q && imem_ready) state_d = StWait;
      StWait: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = StExec;
        end
      end
      StExec: begin
        if (inst_q == Ebreak) begin
          halt_d  = 1'b1;
          state_d = StHalt;
        end else begin
          wen_d    = exu_wen;
          rd_d     = rd;
          sel_d    = npc_sel;
          target_d = npc_target;
          state_d  = StWb;
        end
      end
      StWb: begin
        inst_valid_d = 1'b0;
        if (sel_q && (target_q[1:0] != 2'b00)) begin
          halt_d     = 1'b1;
          halt_err_d = 1'b1;
          state_d    = StHalt;
        end else begin
          pc_d    = sel_q ? target_q : pc_q + XLEN'(4);
          gpr_wen = wen_q && (rd_q != 5'd0);
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
    req_d = (state_d == StFetch);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      halt_q       <= 1'b0;
      halt_err_q   <= 1'b0;
      wen_q        <= 1'b0;
      rd_q         <= '0;
      sel_q        <= 1'b0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      halt_q       <= halt_d;
      halt_err_q   <= halt_err_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      sel_q        <= sel_d;
      target_q     <= target_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc_val     = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign halt       = halt_q;
  assign halt_err   = halt_err_q;

`ifdef CORE_SEQ_PERF_EN
  logic [XLEN-1:0] cycles_q, retired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != StHalt) cycles_q <= cycles_q + XLEN'(1);
      if (retire) retired_q <= retired_q + XLEN'(1);
    end
  end

  assign perf_cycles  = cycles_q;
  assign perf_retired = retired_q;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Table-driven bench for core_seq with a writeback scoreboard fed at fetch-response time.
module tb_core_seq;

  localparam logic [63:0] RstPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exu_wen = 1'b0;
  logic [4:0]  rd = '0;
  logic        npc_sel = 1'b0;
  logic [63:0] npc_target = '0;
  logic        gpr_wen;
  logic [63:0] pc_val;
  logic        halt;
  logic        halt_err;
  logic [63:0] perf_cycles;
  logic [63:0] perf_retired;

  core_seq #(.XLEN(64), .RESET_PC(RstPc)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .exu_wen(exu_wen), .rd(rd), .npc_sel(npc_sel), .npc_target(npc_target),
    .gpr_wen(gpr_wen), .pc_val(pc_val), .halt(halt), .halt_err(halt_err),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] cur_pc = RstPc;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst_before;
    logic [31:0] word;
    logic        wen;
    logic [4:0]  rdn;
    logic        sel;
    logic [63:0] tgt;
    int          rdy;
    int          rv;
    logic        exp_gpr;
    logic [63:0] exp_pc;
    logic        exp_halt;
    logic        exp_err;
  } vec_t;

  logic [63:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every gpr_wen pulse must match an expected writeback, retiring from the queued PC.
  always @(negedge clk) begin
    if (rst === 1'b1 && gpr_wen === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_unexpected_wen: got 1 expected 0 at pc %h", pc_val);
      end else begin
        chk("sb_retire_pc", pc_val, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc_val, RstPc);
    chk("rst_halt", {halt, halt_err, inst_valid, gpr_wen}, 0);
    rst = 1'b1;
    cur_pc = RstPc;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, imem_req, 1);
  endtask

  task automatic run_insn(input vec_t v);
    int c0;
    wait_req("req_wait");
    chk("fetch_addr", imem_addr, cur_pc);
    c0 = cyc;
    exu_wen = v.wen;
    rd = v.rdn;
    npc_sel = v.sel;
    npc_target = v.tgt;
    imem_ready = 1'b0;
    for (int i = 0; i < v.rdy; i++) begin
      @(negedge clk);
      chk("stall_req_addr", {imem_req, imem_addr}, {1'b1, cur_pc});
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("wait_req_low", imem_req, 0);
    for (int i = 0; i < v.rv; i++) @(negedge clk);  // ready stays high here; must be ignored
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = v.word;
    if (v.exp_gpr) sb_q.push_back(cur_pc);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    chk("inst_latch", {inst_valid, inst}, {1'b1, v.word});
    @(negedge clk);
    chk("wb_gpr_wen", gpr_wen, v.exp_gpr);
    chk("wb_cycles", cyc - c0 + 1, 4 + v.rdy + v.rv);
    @(negedge clk);
    chk("next_pc", pc_val, v.exp_pc);
    chk("halt_flags", {halt, halt_err}, {v.exp_halt, v.exp_err});
    chk("next_req", imem_req, !v.exp_halt);
    cur_pc = v.exp_pc;
    if (v.exp_halt) begin
      imem_ready = 1'b1;
      imem_rvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("halt_hold", {imem_req, pc_val, halt}, {1'b0, v.exp_pc, 1'b1});
      end
      imem_ready = 1'b0;
      imem_rvalid = 1'b0;
    end
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst   word          wen rd    sel tgt                     rdy rv gpr next-pc                halt err
    vecs[0]  = '{1'b0, 32'h0010_0093, 1, 5'd1, 0, 64'h0,                  0,  0, 1, 64'h8000_0004,         0, 0};
    vecs[1]  = '{1'b0, 32'h0020_0113, 1, 5'd2, 0, 64'h0,                  3,  1, 1, 64'h8000_0008,         0, 0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 1, 5'd0, 0, 64'h0,                  0,  0, 0, 64'h8000_000C,         0, 0};
    vecs[3]  = '{1'b0, 32'h0000_0063, 0, 5'd5, 0, 64'h0,                  1,  2, 0, 64'h8000_0010,         0, 0};
    vecs[4]  = '{1'b0, 32'h0f00_00ef, 1, 5'd1, 1, 64'h8000_0100,          0,  0, 1, 64'h8000_0100,         0, 0};
    vecs[5]  = '{1'b0, 32'h0000_0067, 0, 5'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 2,  0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0};
    vecs[6]  = '{1'b0, 32'h0030_0193, 1, 5'd3, 0, 64'h0,                  0,  1, 1, 64'h0,                 0, 0};
    vecs[7]  = '{1'b0, 32'h1020_00ef, 1, 5'd3, 1, 64'h8000_0102,          0,  0, 0, 64'h0,                 1, 1};
    vecs[8]  = '{1'b1, 32'h0010_0093, 1, 5'd1, 0, 64'h0,                  0,  0, 1, 64'h8000_0004,         0, 0};
    vecs[9]  = '{1'b0, 32'h0000_0013, 0, 5'd0, 0, 64'h0,                  0,  0, 0, 64'h8000_0008,         0, 0};
    vecs[10] = '{1'b0, 32'h0010_0073, 1, 5'd7, 0, 64'h0,                  1,  1, 0, 64'h8000_0008,         1, 0};

    repeat (2) @(negedge clk);
    chk("por_req", imem_req, 0);
    chk("por_pc", pc_val, RstPc);
    chk("por_inst", {inst_valid, inst}, 0);
    chk("por_flags", {halt, halt_err, gpr_wen}, 0);
    chk("por_perf", {perf_cycles, perf_retired}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_req", {imem_req, imem_addr}, {1'b1, RstPc});

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_insn(vecs[i]);
    end

    // Reset asserted mid-WAIT must abandon the fetch without any writeback.
    do_reset();
    exu_wen = 1'b1;
    rd = 5'd4;
    npc_sel = 1'b0;
    wait_req("rw_req");
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("rw_in_wait", imem_req, 0);
    #2 rst = 1'b0;
    #1;
    chk("rw_async_pc", pc_val, RstPc);
    chk("rw_async_flags", {imem_req, inst_valid, gpr_wen, halt, halt_err}, 0);
    chk("rw_async_inst", inst, 0);
`ifdef CORE_SEQ_PERF_EN
    chk("rw_perf_retired", perf_retired, 0);
`endif
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0010_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rw_held_inst", {inst_valid, inst}, 0);
    rst = 1'b1;
    cur_pc = RstPc;
    wait_req("rw_refetch");
    chk("rw_refetch_addr", imem_addr, RstPc);
    run_insn(vecs[8]);
`ifdef CORE_SEQ_PERF_EN
    chk("perf_retired_one", perf_retired, 1);
`else
    chk("perf_tied", {perf_cycles, perf_retired}, 0);
`endif
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer for the single-issue RV64 core. It owns the program counter and drives the fetch handshake to instruction memory. It latches the fetched word for the decode/execute datapath and issues exactly one GPR write strobe and one PC update per retired instruction. It sits between the instruction-memory port and the idu/exu/RegisterFile datapath in `top`, replacing free-running PC and write-enable wiring with a sequenced fetch–execute–writeback loop.

## Interface
- `XLEN`, 64, datapath and PC width
- `RESET_PC`, 64'h8000_0000, PC value loaded on reset
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, held until accepted
- `imem_addr`  out  XLEN  fetch address, equals `pc_val` while `imem_req`=1
- `imem_ready`  in  1  memory accepts request this cycle (`imem_req` & `imem_ready`)
- `imem_rvalid`  in  1  fetched word valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `inst`  out  32  latched instruction to idu
- `inst_valid`  out  1  `inst` holds a fetched, not-yet-retired instruction
- `exu_wen`  in  1  exu: current instruction writes rd
- `rd`  in  5  destination register from idu
- `npc_sel`  in  1  exu: take `npc_target` instead of pc+4
- `npc_target`  in  XLEN  exu-computed next PC
- `gpr_wen`  out  1  one-cycle GPR write strobe
- `pc_val`  out  XLEN  current PC
- `halt`  out  1  core stopped (sticky)
- `halt_err`  out  1  halt caused by error (misaligned target)
- `perf_cycles`, `perf_retired`  out  XLEN each  performance counters (see Configuration)

## Operation
- States: FETCH, WAIT, EXEC, WB, HALT. Reset state FETCH.
- FETCH: `imem_req`=1. On `imem_ready`=1, go to WAIT. Otherwise stay in FETCH.
- WAIT: `imem_req`=0. On `imem_rvalid`=1, latch `imem_rdata` into `inst`, set `inst_valid`=1, and go to EXEC.
- EXEC: idu/exu evaluate combinationally on `inst`. Sample `npc_sel`, `npc_target`, `exu_wen`, and `rd` into internal registers. Go to WB.
- EXEC, `inst`==32'h0010_0073 (ebreak): go to HALT with `halt_err`=0. PC is not updated and `gpr_wen` is not asserted.
- WB: `gpr_wen` = sampled `exu_wen` & (sampled `rd` != 0). PC ← sampled `npc_sel` ? `npc_target` : `pc_val`+4, with wrap modulo 2^XLEN. `inst_valid` clears. Go to FETCH.
- WB with a selected target whose bits [1:0] != 0: PC is not updated and `gpr_wen`=0. Go to HALT with `halt_err`=1.
- HALT: all strobes stay 0 and outputs hold. Only reset exits this state.
- `imem_rvalid` outside WAIT is ignored. `imem_ready` outside FETCH is ignored.

## Timing
- Reset values: `pc_val`=`RESET_PC`, `inst`=0, `inst_valid`=0, `gpr_wen`=0, `imem_req`=0 while `rst`=0, `halt`=0, `halt_err`=0, counters 0.
- `imem_req` asserts in the first cycle after `rst` deasserts.
- Zero-wait memory (ready in cycle 0, rvalid in cycle 1) gives 4 cycles per instruction: FETCH, WAIT, EXEC, WB. Each extra stall cycle adds one.
- `gpr_wen` is high only in WB, for exactly 1 cycle. The new `pc_val` is visible the cycle after WB, in the same cycle as the next `imem_req`.
- Reset asserted in any state: immediate asynchronous return to reset values. A pending fetch is abandoned and no `gpr_wen` is issued.
- All outputs are registered except `imem_addr` (=`pc_val`) and `gpr_wen` (decoded from state plus registered samples).

## Configuration
- `CORE_SEQ_PERF_EN` defined: `perf_cycles` increments every non-HALT cycle after reset. `perf_retired` increments on every WB that updates the PC. Both wrap modulo 2^XLEN.
- Undefined: both counters are removed, and `perf_cycles`/`perf_retired` are tied to 0.

## Test plan
- Zero-wait memory feeding addi x1,x0,1 (0x00100093): `imem_addr`=0x8000_0000 → `gpr_wen` pulses in cycle 4 with rd=1 → `pc_val`=0x8000_0004 in cycle 5.
- `imem_ready` delayed 3 cycles and `imem_rvalid` delayed 2 cycles: `imem_req` stays high and `imem_addr` stays stable. Retire occurs in cycle 8, with a single `gpr_wen` pulse.
- Instruction with rd=0 and `exu_wen`=1: `gpr_wen` stays 0 and PC advances by 4.
- ebreak fetched at 0x8000_0008: `halt`=1, `halt_err`=0, `pc_val` stays 0x8000_0008. After that, no further `imem_req` and no `gpr_wen`.
- `npc_sel`=1 with `npc_target`=0x8000_0102: `halt`=1, `halt_err`=1, PC unchanged. With `npc_target`=0x8000_0100, the next fetch goes to 0x8000_0100.
- `rst` pulled low during WAIT: outputs return to reset values at once with no `gpr_wen`. The first fetch after release is at 0x8000_0000. With `CORE_SEQ_PERF_EN`, `perf_retired`=0 after this reset.
